// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    FULL  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_skid.sv
// One-entry {pc, instr} holding register that absorbs a fetch accepted while decode stalls.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [ILEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [ILEN-1:0] instr_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] instr_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= ILEN'(NOP_INSTR);
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem valid/ack handshake, IF/ID register, redirects.
// Optional skid buffer and FULL state are built when FETCH_SKID_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [ILEN-1:0] ifid_instr,
  output logic            fault_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [ILEN-1:0] ifid_instr_q, ifid_instr_d;
  logic            accept;

`ifdef FETCH_SKID_EN
  logic            skid_load, skid_clear, skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [ILEN-1:0] skid_instr;

  fetch_skid #(.XLEN(XLEN), .ILEN(ILEN)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  assign imem_req = (state_q == REQ);
`else
  // Without a skid there is nowhere to park a fetch while decode stalls.
  assign imem_req = (state_q == REQ) && !(ifid_valid_q && stall_i);
`endif

  assign accept    = imem_req && imem_ack;
  assign imem_addr = pc_q;
  assign fault_o   = (state_q == FAULT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
`ifdef FETCH_SKID_EN
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
`endif
    if (redirect_i) begin
      ifid_valid_d = 1'b0;
      pc_d         = redirect_pc_i;
      state_d      = (redirect_pc_i[1:0] == 2'b00) ? REQ : FAULT;
`ifdef FETCH_SKID_EN
      skid_clear   = 1'b1;
`endif
    end else begin
      case (state_q)
        REQ: begin
          if (accept) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
`ifdef FETCH_SKID_EN
            if (ifid_valid_q && stall_i) begin
              skid_load = 1'b1;
              state_d   = FULL;
            end else
`endif
            begin
              ifid_valid_d = 1'b1;
              ifid_pc_d    = pc_q;
              ifid_instr_d = imem_rdata;
            end
          end else if (!stall_i) begin
            ifid_valid_d = 1'b0;
          end
        end
`ifdef FETCH_SKID_EN
        FULL: begin
          if (!stall_i && skid_valid) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = skid_pc;
            ifid_instr_d = skid_instr;
            skid_clear   = 1'b1;
            state_d      = REQ;
          end
        end
`endif
        FAULT: ifid_valid_d = 1'b0;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= ILEN'(NOP_INSTR);
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequence then random stimulus vs a queue-based model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        fault_o;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(64), .ILEN(32), .RESET_PC(64'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .fault_o       (fault_o)
  );

  // Instruction memory content is a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction
  assign imem_rdata = memf(imem_addr);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Model: fetched-but-undelivered instructions wait in a queue (at most one with a skid).
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_pc = '0;
  logic        m_v = 1'b0;
  logic        m_halt = 1'b0;
  logic [63:0] m_ipc = '0;
  logic [31:0] m_ins = '0;
  bit          m_known = 1'b0;

  function automatic bit model_req(input bit st);
`ifdef FETCH_SKID_EN
    return !m_halt && (m_q.size() == 0);
`else
    return !m_halt && !(m_v && st);
`endif
  endfunction

  task automatic step(input bit rst, input bit st, input bit ack, input bit rd, input logic [63:0] rpc);
    bit   req;
    ent_t e;
    reset         = rst;
    stall_i       = st;
    imem_ack      = ack;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    #1;
    req = model_req(st);
    if (m_known) begin
      check("imem_req", {63'b0, imem_req}, {63'b0, req});
      check("imem_addr", imem_addr, m_pc);
      check("fault_pre", {63'b0, fault_o}, {63'b0, m_halt});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_pc = 64'h0; m_v = 1'b0; m_halt = 1'b0;
      m_ipc = '0; m_ins = NOP_INSTR; m_q.delete(); m_known = 1'b1;
    end else if (rd) begin
      m_v = 1'b0; m_q.delete(); m_pc = rpc; m_halt = (rpc[1:0] != 2'b00);
    end else if (m_halt) begin
      m_v = 1'b0;
    end else if (m_q.size() != 0) begin
      if (!st) begin
        e = m_q.pop_front();
        m_ipc = e.pc; m_ins = e.ins; m_v = 1'b1;
      end
    end else if (req && ack) begin
      if (!m_v || !st) begin
        m_ipc = m_pc; m_ins = memf(m_pc); m_v = 1'b1;
      end else begin
        m_q.push_back('{m_pc, memf(m_pc)});
      end
      m_pc = m_pc + 64'd4;
    end else if (!st) begin
      m_v = 1'b0;
    end
    check("ifid_valid", {63'b0, ifid_valid}, {63'b0, m_v});
    if (m_v || rst) begin
      check("ifid_pc", ifid_pc, m_ipc);
      check("ifid_instr", {32'b0, ifid_instr}, {32'b0, m_ins});
    end
    check("fault", {63'b0, fault_o}, {63'b0, m_halt});
    $display("cyc=%0d rst=%0b stall=%0b ack=%0b rd=%0b rpc=%h | req=%0b addr=%h ifid_v=%0b ifid_pc=%h fault=%0b",
             cyc, rst, st, ack, rd, rpc, imem_req, imem_addr, ifid_valid, ifid_pc, fault_o);
  endtask

  initial begin
    logic [63:0] t;
    reset = 1'b1; stall_i = 1'b0; imem_ack = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

    // Directed: reset, streaming, ack gap, stall, redirects, fault, wrap, reset during stall.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 64'h100);
    step(0, 1, 1, 1, 64'h100);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 64'h102);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 64'h200);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 1, 64'h40);
    step(0, 0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      t = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       t[1:0] = 2'($urandom_range(1, 3));
        1:       t = 64'hFFFF_FFFF_FFFF_FFF8;
        default: t[1:0] = 2'b00;
      endcase
      step($urandom_range(0, 99) < 1,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 5,
           t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
